// File: rtl/esm_order_restore.sv
// esm_order_restore: re-emits instructions from the shuffler in original sequence order.
// Each incoming instruction carries its sequence slot (mod bs); entries park in a bs-deep
// reorder store and leave through a registered output stage strictly in tag order.
// Optional feature: define ESM_RESTORE_TIMEOUT_EN to skip a head slot that stays empty
// for TIMEOUT stall cycles (skip pulses for one cycle when that happens).
module esm_order_restore #(
  parameter int unsigned Instr_word_size = 32,
  parameter int unsigned bs              = 16,
  parameter int unsigned TIMEOUT         = 64,
  localparam int unsigned TW             = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] Instr_in,
  input  logic [TW-1:0]              Instr_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Instr_word_size-1:0] Instr_out,
  output logic [TW-1:0]              out_tag,
  output logic [TW:0]                count,
  output logic                       skip
);

  logic [Instr_word_size-1:0] mem [bs];
  logic [bs-1:0]              vld;
  logic [TW-1:0]              head;
  logic                       accept;
  logic                       load;
  logic                       skip_now;

  // A slot can only be written while it is free; this also blocks the head slot while it drains.
  assign in_ready = !vld[Instr_tag];
  assign accept   = in_valid && in_ready;
  assign load     = (!out_valid || out_ready) && vld[head];

  // Reorder storage payload; validity is tracked separately so the array needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[Instr_tag] <= Instr_in;
    end
  end

  // Slot validity, head pointer, occupancy count and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      vld       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      Instr_out <= '0;
      out_tag   <= '0;
    end else begin
      if (accept) begin
        vld[Instr_tag] <= 1'b1;
      end
      if (load) begin
        Instr_out <= mem[head];
        out_tag   <= head;
        out_valid <= 1'b1;
        vld[head] <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Head wraps naturally because bs is a power of two.
      if (load || skip_now) begin
        head <= head + 1'b1;
      end
      if (accept && !load) begin
        count <= count + 1'b1;
      end else if (!accept && load) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef ESM_RESTORE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] timer;
  logic          stall;

  // Stalled: something is buffered but the slot we are waiting for never arrived.
  assign stall    = (count != '0) && !vld[head];
  assign skip_now = stall && (timer == CW'(TIMEOUT - 1));

  // Stall timer; gives up on the head slot after TIMEOUT consecutive stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      skip  <= 1'b0;
    end else begin
      skip <= skip_now;
      if (!stall || skip_now) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign skip_now       = 1'b0;
  assign skip           = 1'b0;
`endif

endmodule

// File: tb/tb_esm_order_restore.sv
// Bench for esm_order_restore: directed scenarios plus randomized streams, checked against
// the rule "outputs appear in original sequence order", modelled as an ordered queue.
`timescale 1ns/1ps
module tb_esm_order_restore;
  localparam int W  = 32;
  localparam int BS = 16;
  localparam int TO = 8;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  Instr_in = '0;
  logic [3:0]    Instr_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  Instr_out;
  logic [3:0]    out_tag;
  logic [4:0]    count;
  logic          skip;

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  bit    rand_rdy = 0;
  item_t got[$];
  int    got_cyc[$];
  int    skip_cyc[$];

  esm_order_restore #(
    .Instr_word_size(W),
    .bs             (BS),
    .TIMEOUT        (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Instr_in (Instr_in),
    .Instr_tag(Instr_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Instr_out(Instr_out),
    .out_tag  (out_tag),
    .count    (count),
    .skip     (skip)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every completed output handshake and every skip pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got.push_back({out_tag, Instr_out});
        got_cyc.push_back(cyc);
      end
      if (skip) skip_cyc.push_back(cyc);
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    got_cyc.delete();
    skip_cyc.delete();
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [3:0] tag, input logic [31:0] d);
    bit acc = 0;
    in_valid = 1'b1;
    Instr_tag = tag;
    Instr_in = d;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    acc_cyc = cyc;
    n_chk++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout tag=%0d: accepted=0 required=1", tag);
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 3000 && got.size() < n; k++) tick();
    repeat (5) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (out_valid !== 1'b0 || count !== 5'd0 || skip !== 1'b0 || Instr_out !== '0 ||
        out_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b count=%0d skip=%b Instr_out=%h out_tag=%0d required all 0",
               out_valid, count, skip, Instr_out, out_tag);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_in_order();
    apply_reset();
    out_ready = 1'b1;
    send(4'd0, 32'hA0);
    n_chk++;
    if (out_valid !== 1'b0 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL in_order_no_bypass: out_valid=%b count=%0d required 0/1", out_valid, count);
    end
    send(4'd1, 32'hA1);
    n_chk++;
    if (out_valid !== 1'b1 || Instr_out !== 32'hA0 || out_tag !== 4'd0 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL in_order_latency: out_valid=%b Instr_out=%h tag=%0d count=%0d required 1/a0/0/1",
               out_valid, Instr_out, out_tag, count);
    end
    for (int i = 2; i < 4; i++) begin
      send(4'(i), 32'hA0 + i);
      n_chk++;
      if (count > 5'd1) begin
        n_fail++;
        $display("FAIL in_order_count: got %0d required <=1", count);
      end
    end
    wait_outputs(4);
    n_chk++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL in_order_size: got %0d required 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_chk++;
      if (got[i] !== {4'(i), 32'hA0 + i}) begin
        n_fail++;
        $display("FAIL in_order_out[%0d]: got %h required %h", i, got[i], {4'(i), 32'hA0 + i});
      end
    end
    n_chk++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL in_order_empty: out_valid=%b count=%0d required 0/0", out_valid, count);
    end
  endtask

  task automatic test_reversed();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 3; i >= 1; i--) send(4'(i), 32'hB0 + i);
    repeat (3) tick();
    n_chk++;
    if (got.size() != 0 || out_valid !== 1'b0 || count !== 5'd3) begin
      n_fail++;
      $display("FAIL reversed_hold: outputs=%0d out_valid=%b count=%0d required 0/0/3",
               got.size(), out_valid, count);
    end
    send(4'd0, 32'hB0);
    n_chk++;
    if (count !== 5'd4) begin
      n_fail++;
      $display("FAIL reversed_count4: got %0d required 4", count);
    end
    wait_outputs(4);
    n_chk++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL reversed_size: got %0d required 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_chk++;
      if (got[i] !== {4'(i), 32'hB0 + i}) begin
        n_fail++;
        $display("FAIL reversed_out[%0d]: got %h required %h", i, got[i], {4'(i), 32'hB0 + i});
      end
      if (i > 0) begin
        n_chk++;
        if (got_cyc[i] - got_cyc[i-1] != 1) begin
          n_fail++;
          $display("FAIL reversed_gap[%0d]: got %0d cycles required 1", i,
                   got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    n_chk++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL reversed_count0: got %0d required 0", count);
    end
  endtask

  task automatic test_full();
    logic [31:0] d[16];
    int ord[15];
    int j, tmp;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = $urandom;
    for (int k = 0; k < 15; k++) ord[k] = k + 1;
    for (int k = 14; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
    end
    for (int k = 0; k < 15; k++) send(4'(ord[k]), d[ord[k]]);
    send(4'd0, d[0]);
    n_chk++;
    if (count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_count: got %0d required 16", count);
    end
    for (int t = 0; t < 16; t++) begin
      Instr_tag = 4'(t);
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_in_ready[%0d]: got %b required 0", t, in_ready);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || Instr_out !== d[0] || out_tag !== 4'd0) begin
        n_fail++;
        $display("FAIL full_hold: out_valid=%b Instr_out=%h tag=%0d required 1/%h/0",
                 out_valid, Instr_out, out_tag, d[0]);
      end
    end
    // Head entry now sits in the output register, so one slot is counted out.
    n_chk++;
    if (count !== 5'd15) begin
      n_fail++;
      $display("FAIL full_count_held: got %0d required 15", count);
    end
    out_ready = 1'b1;
    wait_outputs(16);
    n_chk++;
    if (got.size() != 16) begin
      n_fail++;
      $display("FAIL full_size: got %0d required 16", got.size());
    end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_chk++;
      if (got[i] !== {4'(i), d[i]}) begin
        n_fail++;
        $display("FAIL full_out[%0d]: got %h required %h", i, got[i], {4'(i), d[i]});
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    rand_rdy = 1;
    for (int p = 0; p < 40; p += 2) begin
      send(4'((p + 1) % 16), 32'h100 + p + 1);
      if ($urandom_range(0, 2) == 0) tick();
      send(4'(p % 16), 32'h100 + p);
    end
    wait_outputs(40);
    rand_rdy = 0;
    out_ready = 1'b1;
    n_chk++;
    if (got.size() != 40) begin
      n_fail++;
      $display("FAIL wrap_size: got %0d required 40", got.size());
    end
    for (int i = 0; i < got.size() && i < 40; i++) begin
      n_chk++;
      if (got[i] !== {4'(i % 16), 32'h100 + i}) begin
        n_fail++;
        $display("FAIL wrap_out[%0d]: got %h required %h", i, got[i], {4'(i % 16), 32'h100 + i});
      end
    end
  endtask

  // Random data, sequence numbers shuffled within each window of 16, random gaps and backpressure.
  task automatic test_random_stream();
    item_t exp_q[$];
    logic [31:0] d[64];
    int ord[16];
    int j, tmp, s;
    apply_reset();
    rand_rdy = 1;
    for (int i = 0; i < 64; i++) begin
      d[i] = $urandom;
      exp_q.push_back({4'(i % 16), d[i]});
    end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 16; k++) ord[k] = k;
      for (int k = 15; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
      end
      for (int k = 0; k < 16; k++) begin
        s = b * 16 + ord[k];
        if ($urandom_range(0, 3) == 0) tick();
        send(4'(s % 16), d[s]);
      end
    end
    wait_outputs(64);
    rand_rdy = 0;
    out_ready = 1'b1;
    n_chk++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_size: got %0d required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_out[%0d]: got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) send(4'(i), 32'hD0 + i);
    n_chk++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL reset_mid_pre: count=%0d required 3", count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: count=%0d out_valid=%b required 0/0", count, out_valid);
    end
    send(4'd0, 32'hC0);
    repeat (12) tick();
    n_chk++;
    if (got.size() != 1) begin
      n_fail++;
      $display("FAIL reset_mid_size: got %0d required 1", got.size());
    end else begin
      n_chk++;
      if (got[0] !== {4'd0, 32'hC0}) begin
        n_fail++;
        $display("FAIL reset_mid_out: got %h required %h", got[0], {4'd0, 32'hC0});
      end
    end
  endtask

  task automatic test_timeout();
    int first_acc;
    apply_reset();
    out_ready = 1'b1;
    send(4'd1, 32'hE1);
    first_acc = acc_cyc;
    send(4'd2, 32'hE2);
    repeat (30) tick();
`ifdef ESM_RESTORE_TIMEOUT_EN
    n_chk++;
    if (skip_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_skip_pulses: got %0d required 1", skip_cyc.size());
    end else begin
      n_chk++;
      if (skip_cyc[0] != first_acc + TO) begin
        n_fail++;
        $display("FAIL timeout_skip_time: got cycle %0d required %0d", skip_cyc[0], first_acc + TO);
      end
    end
    n_chk++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL timeout_size: got %0d required 2", got.size());
    end else begin
      n_chk++;
      if (got[0] !== {4'd1, 32'hE1} || got[1] !== {4'd2, 32'hE2}) begin
        n_fail++;
        $display("FAIL timeout_out: got %h %h required %h %h", got[0], got[1],
                 {4'd1, 32'hE1}, {4'd2, 32'hE2});
      end
    end
`else
    n_chk++;
    if (skip_cyc.size() != 0 || got.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_stall: skips=%0d outputs=%0d out_valid=%b required 0/0/0 (first acc %0d)",
               skip_cyc.size(), got.size(), out_valid, first_acc);
    end
    n_chk++;
    if (count !== 5'd2) begin
      n_fail++;
      $display("FAIL no_timeout_count: got %0d required 2", count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reversed();
    test_full();
    test_wrap();
    test_random_stream();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
